// File: rtl/color_arb_pkg.sv
// Shared types and command constants for the Color FSM command arbiter.
// Imported by the round-robin picker and the arbiter top.
package color_arb_pkg;

   typedef enum logic {
      BLUE = 1'b0,
      RED  = 1'b1
   } color_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_e;

   localparam logic [1:0] CMD_STAY   = 2'h0;
   localparam logic [1:0] CMD_TOGGLE = 2'h1;
   localparam logic [1:0] CMD_NOP    = 2'h3;

   localparam int TMO_W = 8;

   // Only STAY and TOGGLE move (or hold) the FSM; other codes are no-ops.
   function automatic logic cmd_acts(input logic [1:0] cmd);
      return (cmd == CMD_STAY) || (cmd == CMD_TOGGLE);
   endfunction

   function automatic color_e expect_color(input logic [1:0] cmd,
                                           input logic      cur);
      return color_e'(cur ^ (cmd == CMD_TOGGLE));
   endfunction

endpackage

// File: rtl/color_cmd_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_picker
   import color_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   int c;

   // Scan from farthest to nearest so the nearest hit is written last.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      c     = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         c = int'(ptr) + k;
         if (c >= NUM_REQ) begin
            c = c - NUM_REQ;
         end
         if (req[IDX_W'(c)]) begin
            valid = 1'b1;
            idx   = IDX_W'(c);
         end
      end
   end

endmodule

// File: rtl/color_cmd_arbiter.sv
// Round-robin arbiter sharing the Color FSM command input among requesters;
// issues one command, waits for the expected state or a timeout.
module color_cmd_arbiter
   import color_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [2*NUM_REQ-1:0] req_cmd,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [NUM_REQ-1:0]   done,
   output logic                 err,
   output logic [1:0]           fsm_cmd,
   input  logic                 fsm_state,
   output logic                 busy,
   output logic [CNT_W-1:0]     toggle_count
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   arb_state_e         state_q, state_d;
   logic [IDX_W-1:0]   win_q, win_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [1:0]         cmd_q, cmd_d;
   color_e             exp_q, exp_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               err_q, err_d;
   logic [1:0]         fsm_cmd_q, fsm_cmd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               pick_vld;
   logic [IDX_W-1:0]   pick_idx;
   logic [TMO_W-1:0]   tmo_inc;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   assign tmo_inc = tmo_q + TMO_W'(1);

   always_comb begin
      state_d   = state_q;
      win_d     = win_q;
      ptr_d     = ptr_q;
      cmd_d     = cmd_q;
      exp_d     = exp_q;
      tmo_d     = tmo_q;
      gnt_d     = gnt_q;
      done_d    = '0;
      err_d     = 1'b0;
      fsm_cmd_d = CMD_NOP;
      cnt_d     = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (pick_vld) begin
               win_d           = pick_idx;
               cmd_d           = req_cmd[2*pick_idx +: 2];
               gnt_d           = '0;
               gnt_d[pick_idx] = 1'b1;
               fsm_cmd_d       = req_cmd[2*pick_idx +: 2];
               state_d         = ISSUE;
            end
         end
         ISSUE: begin
            exp_d   = expect_color(cmd_q, fsm_state);
            tmo_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // No-op codes never move the FSM, so they finish immediately.
            if (!cmd_acts(cmd_q) || (color_e'(fsm_state) == exp_q)) begin
               done_d  = gnt_q;
               state_d = DONE;
            end else begin
               tmo_d = tmo_inc;
               if (tmo_inc == TMO_MAX) begin
                  done_d  = gnt_q;
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if ((cmd_q == CMD_TOGGLE) && !err_q) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            ptr_d   = (win_q == LAST_IDX) ? '0 : win_q + IDX_W'(1);
            gnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         win_q     <= '0;
         ptr_q     <= '0;
         cmd_q     <= CMD_NOP;
         exp_q     <= BLUE;
         tmo_q     <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         err_q     <= 1'b0;
         fsm_cmd_q <= CMD_NOP;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         win_q     <= win_d;
         ptr_q     <= ptr_d;
         cmd_q     <= cmd_d;
         exp_q     <= exp_d;
         tmo_q     <= tmo_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         err_q     <= err_d;
         fsm_cmd_q <= fsm_cmd_d;
         cnt_q     <= cnt_d;
      end
   end

   assign gnt          = gnt_q;
   assign done         = done_q;
   assign err          = err_q;
   assign fsm_cmd      = fsm_cmd_q;
   assign busy         = (state_q != IDLE);
   assign toggle_count = cnt_q;

endmodule

// File: tb/tb_color_cmd_arbiter.sv
// Randomized bench for color_cmd_arbiter with a transaction-level model
// and a Color FSM stand-in that can be forced stuck at Blue.
module tb_color_cmd_arbiter;

   localparam int N   = 4;
   localparam int TMO = 15;
   localparam int CW  = 8;
   localparam logic [1:0] STAY = 2'h0;
   localparam logic [1:0] TOG  = 2'h1;
   localparam logic [1:0] NOP  = 2'h3;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   req = '0;
   logic [2*N-1:0] req_cmd = '0;
   logic [N-1:0]   gnt, done;
   logic           err;
   logic [1:0]     fsm_cmd;
   logic           fsm_state;
   logic           busy;
   logic [CW-1:0]  toggle_count;

   logic           col;
   logic           stuck = 1'b0;
   logic [N-1:0]   done_prev = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   color_cmd_arbiter #(
      .NUM_REQ (N),
      .TIMEOUT (TMO),
      .CNT_W   (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_cmd      (req_cmd),
      .gnt          (gnt),
      .done         (done),
      .err          (err),
      .fsm_cmd      (fsm_cmd),
      .fsm_state    (fsm_state),
      .busy         (busy),
      .toggle_count (toggle_count)
   );

   // Color FSM stand-in: resets to Red, TOGGLE flips it.
   always @(posedge clk or negedge rst) begin
      if (!rst) col <= 1'b1;
      else if (fsm_cmd == TOG) col <= ~col;
   end
   assign fsm_state = stuck ? 1'b0 : col;

   always @(negedge clk) done_prev <= done;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one grant at a time, fixed timeline per grant.
   int         cyc = 0;
   bit         m_busy = 0;
   int         m_win = 0, m_t0 = 0, m_tdone = 0, m_ptr = 0, m_cnt = 0;
   logic [1:0] m_cmd = NOP;
   bit         m_err = 0;

   always @(negedge clk) begin
      logic [N-1:0] eg, ed;
      logic [1:0]   ec;
      if (!rst) begin
         m_busy = 0; m_ptr = 0; m_cnt = 0; m_err = 0; cyc = 0;
      end
      eg = m_busy ? N'(1 << m_win) : '0;
      ed = (m_busy && cyc == m_tdone) ? N'(1 << m_win) : '0;
      ec = (m_busy && cyc == m_t0 + 1) ? m_cmd : NOP;
      chk("gnt", 32'(gnt), 32'(eg));
      chk("done", 32'(done), 32'(ed));
      chk("err", 32'(err), 32'(m_busy && cyc == m_tdone && m_err));
      chk("fsm_cmd", 32'(fsm_cmd), 32'(ec));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("toggle_count", 32'(toggle_count), 32'(m_cnt));
      if (rst) begin
         if (m_busy) begin
            if (cyc == m_tdone) begin
               m_busy = 0;
               m_ptr  = (m_win + 1) % N;
               if (m_cmd == TOG && !m_err) m_cnt = (m_cnt + 1) % (1 << CW);
            end
         end else begin
            for (int k = 0; k < N; k++) begin
               int i;
               i = (m_ptr + k) % N;
               if (req[i]) begin
                  m_busy  = 1;
                  m_win   = i;
                  m_cmd   = req_cmd[2*i +: 2];
                  m_t0    = cyc;
                  m_err   = (m_cmd == TOG) && stuck;
                  m_tdone = cyc + (m_err ? 2 + TMO : 3);
                  break;
               end
            end
         end
         cyc++;
      end
   end

   task automatic do_reset();
      rst = 1'b0; req = '0; req_cmd = '0; stuck = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_fsm_cmd", 32'(fsm_cmd), 32'h3);
      chk("rst_count", 32'(toggle_count), 32'h0);
      @(posedge clk); #1 rst = 1'b1;
   endtask

   task automatic rand_run(input int ncyc);
      repeat (ncyc) begin
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            if (req[i]) begin
               if (done_prev[i]) begin
                  if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
               end else if ($urandom_range(39, 0) == 0) begin
                  req[i] = 1'b0;
               end
            end else if ($urandom_range(3, 0) == 0) begin
               req[i] = 1'b1;
               req_cmd[2*i +: 2] = 2'($urandom_range(3, 0));
            end
         end
      end
      @(posedge clk); #1 req = '0;
      repeat (20) @(posedge clk);
      #1;
   endtask

   initial begin
      int k, n;
      do_reset();

      // Single TOGGLE from requester 1 with FSM at Red.
      @(posedge clk); #1 req = 4'b0010; req_cmd = 8'h04;
      @(negedge clk); chk("t1_c0_gnt", 32'(gnt), 32'h0);
      @(negedge clk);
      chk("t1_c1_gnt", 32'(gnt), 32'h2);
      chk("t1_c1_cmd", 32'(fsm_cmd), 32'h1);
      @(negedge clk);
      chk("t1_c2_cmd", 32'(fsm_cmd), 32'h3);
      chk("t1_c2_state", 32'(fsm_state), 32'h0);
      @(negedge clk);
      chk("t1_c3_done", 32'(done), 32'h2);
      chk("t1_c3_err", 32'(err), 32'h0);
      @(posedge clk); #1 req = '0;
      @(negedge clk); chk("t1_count", 32'(toggle_count), 32'h1);

      // TOGGLE against an FSM stuck at Blue times out.
      @(posedge clk); #1 stuck = 1'b1; req = 4'b0001; req_cmd = 8'h01;
      for (k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done != '0) break;
      end
      chk("tmo_cycle", 32'(k), 32'd17);
      chk("tmo_done", 32'(done), 32'h1);
      chk("tmo_err", 32'(err), 32'h1);
      @(posedge clk); #1 req = '0; stuck = 1'b0;
      @(negedge clk); chk("tmo_count", 32'(toggle_count), 32'h1);

      // Requester 2 drops req during WAIT; pointer then wraps to 0.
      @(posedge clk); #1 req = 4'b0100; req_cmd = 8'h00;
      @(posedge clk); @(posedge clk); #1 req = 4'b0001;
      @(negedge clk);
      @(negedge clk); chk("drop_done", 32'(done), 32'h4);
      @(negedge clk);
      @(negedge clk); chk("drop_next_gnt", 32'(gnt), 32'h1);
      repeat (3) @(posedge clk);
      #1 req = '0;

      // Asynchronous reset while in WAIT.
      @(posedge clk); #1 req = 4'b0010; req_cmd = 8'h00;
      @(posedge clk); @(posedge clk); #3 rst = 1'b0;
      #1;
      chk("arst_gnt", 32'(gnt), 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_cmd", 32'(fsm_cmd), 32'h3);
      chk("arst_done", 32'(done), 32'h0);
      req = 4'b1001;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk); chk("arst_c0_done", 32'(done), 32'h0);
      @(negedge clk); chk("arst_ptr0_gnt", 32'(gnt), 32'h1);
      @(negedge clk); @(negedge clk);
      @(posedge clk); #1 req = '0;

      // All four requesters holding STAY: strict rotation.
      do_reset();
      @(posedge clk); #1 req = 4'b1111; req_cmd = 8'h00;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (c % 4 == 1) chk("rr_gnt", 32'(gnt), 32'(1 << (c / 4)));
      end
      @(posedge clk); #1 req = '0;
      @(negedge clk); chk("rr_count", 32'(toggle_count), 32'h0);

      // 256 successful toggles wrap the counter.
      do_reset();
      @(posedge clk); #1 req = 4'b0001; req_cmd = 8'h01;
      n = 0;
      for (int c = 0; c < 256 * 4 + 40; c++) begin
         @(negedge clk);
         if (done[0]) begin
            n++;
            chk("wrap_state", 32'(fsm_state), 32'(1 ^ (n & 1)));
            if (n == 256) break;
         end
      end
      chk("wrap_n", 32'(n), 32'd256);
      chk("wrap_pre", 32'(toggle_count), 32'd255);
      @(posedge clk); #1 req = '0;
      @(negedge clk); chk("wrap_count", 32'(toggle_count), 32'h0);

      // Randomized traffic, healthy FSM then stuck FSM.
      @(posedge clk); #1;
      rand_run(1500);
      stuck = 1'b1;
      rand_run(800);
      stuck = 1'b0;
      rand_run(600);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
